// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_cmd_pkg;

  // Frame assembly state: waiting for header, address, or data byte.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  // Default frame header byte.
  localparam logic [7:0] HEADER_DEFAULT = 8'h3F;

  // Causes of an error pulse.
  localparam logic [1:0] BAD_HEADER = 2'd0;
  localparam logic [1:0] BAD_ADDR   = 2'd1;
  localparam logic [1:0] TIMEOUT    = 2'd2;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte gap watchdog: expires when TIMEOUT_CLKS cycles pass in a frame with no byte.
// Latency: expire_o is combinational from the counter; asserted in the TIMEOUT_CLKS-th quiet cycle.
// Backpressure: none; clear_i (a byte arriving) always overrides expiry in the same cycle.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CLKS = 2140
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int            CW   = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A byte in the final cycle clears the count, so it is never seen as a timeout.
  assign expire_o = run_i && !clear_i && (cnt_q == LAST);

  // Count quiet cycles while a frame is open; restart on any byte, on idle, or on expiry.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || !run_i || expire_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 3-byte frames (header, address, data) from the UART RX stream into a config register file.
// Latency: register, write strobe and error pulse all update on the edge that samples the data byte.
// Backpressure: none; every in_rx_valid strobe is consumed. UART_CMD_PARSER_FRAME_TIMEOUT_EN adds a frame timeout.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] HEADER       = HEADER_DEFAULT,
  parameter int         NUM_REGS     = 4,
  parameter int         CLKS_PER_BIT = 107,
  parameter int         TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic                  in_rx_valid,
  input  logic [7:0]            in_rx_byte,
  output logic                  out_wr_valid,
  output logic [7:0]            out_wr_addr,
  output logic [7:0]            out_wr_data,
  output logic [NUM_REGS*8-1:0] out_regs,
  output logic                  out_err,
  output logic [7:0]            out_err_cnt,
  output logic                  out_busy
);

  // Addresses are one byte wide, so at most 256 registers are reachable.
  if (NUM_REGS < 1 || NUM_REGS > 256 || CLKS_PER_BIT < 1 || TIMEOUT_CLKS < 2) begin : g_param_err
    $error("uart_cmd_parser: illegal parameter combination");
  end

  state_e                state_q, state_d;
  logic [7:0]            addr_q, addr_d;
  logic [NUM_REGS*8-1:0] regs_q, regs_d;
  logic                  wr_vld_q, wr_vld_d;
  logic [7:0]            wr_addr_q, wr_addr_d;
  logic [7:0]            wr_dat_q, wr_dat_d;
  logic                  err_q, err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  timeout_hit;
  logic                  addr_ok;

`ifdef UART_CMD_PARSER_FRAME_TIMEOUT_EN
  uart_cmd_timeout #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timeout (
    .clk_i    (in_clk),
    .rst_i    (in_reset),
    .clear_i  (in_rx_valid),
    .run_i    (state_q != IDLE),
    .expire_o (timeout_hit)
  );
`else
  // Without the watchdog a partial frame waits indefinitely.
  assign timeout_hit = 1'b0;
`endif

  assign addr_ok = (32'(addr_q) < NUM_REGS);

  // Next-state, register-file write and error accounting.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    regs_d    = regs_q;
    wr_vld_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_dat_d  = wr_dat_q;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_rx_valid) begin
          if (in_rx_byte == HEADER) begin
            state_d = ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ADDR: begin
        // Any byte here is an address, including one equal to the header.
        if (in_rx_valid) begin
          addr_d  = in_rx_byte;
          state_d = DATA;
        end else if (timeout_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      DATA: begin
        if (in_rx_valid) begin
          state_d = IDLE;
          if (addr_ok) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              if (addr_q == 8'(k)) begin
                regs_d[8*k +: 8] = in_rx_byte;
              end
            end
            wr_vld_d  = 1'b1;
            wr_addr_d = addr_q;
            wr_dat_d  = in_rx_byte;
          end else begin
            err_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  // State and output registers; reset discards any partial frame silently.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      regs_q    <= '0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      regs_q    <= regs_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_dat_q  <= wr_dat_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_wr_valid = wr_vld_q;
  assign out_wr_addr  = wr_addr_q;
  assign out_wr_data  = wr_dat_q;
  assign out_regs     = regs_q;
  assign out_err      = err_q;
  assign out_err_cnt  = err_cnt_q;
  assign out_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frame writes, bad header/address, reset mid-frame,
// inter-byte gap (with or without UART_CMD_PARSER_FRAME_TIMEOUT_EN), error counter saturation.
// Inputs driven and outputs sampled on the falling edge.
module tb_uart_cmd_parser;

  logic        in_clk;
  logic        in_reset;
  logic        in_rx_valid;
  logic [7:0]  in_rx_byte;
  logic        out_wr_valid;
  logic [7:0]  out_wr_addr;
  logic [7:0]  out_wr_data;
  logic [31:0] out_regs;
  logic        out_err;
  logic [7:0]  out_err_cnt;
  logic        out_busy;

  int checks = 0;
  int errors = 0;
  int n_err  = 0;
  int n_wr   = 0;
  int err_base;

  uart_cmd_parser #(
    .NUM_REGS     (4),
    .TIMEOUT_CLKS (50)
  ) dut (
    .in_clk       (in_clk),
    .in_reset     (in_reset),
    .in_rx_valid  (in_rx_valid),
    .in_rx_byte   (in_rx_byte),
    .out_wr_valid (out_wr_valid),
    .out_wr_addr  (out_wr_addr),
    .out_wr_data  (out_wr_data),
    .out_regs     (out_regs),
    .out_err      (out_err),
    .out_err_cnt  (out_err_cnt),
    .out_busy     (out_busy)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // Count one-cycle pulses just after each rising edge.
  always begin
    @(posedge in_clk);
    #1;
    if (out_err) n_err++;
    if (out_wr_valid) n_wr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge in_clk);
  endtask

  // One-cycle strobe; returns on the falling edge after the sampling edge.
  task automatic send(input logic [7:0] b);
    in_rx_valid = 1'b1;
    in_rx_byte  = b;
    @(negedge in_clk);
    in_rx_valid = 1'b0;
    in_rx_byte  = 8'h00;
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    tick(2);
    in_reset = 1'b0;
    tick(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_reset    = 1'b1;
    in_rx_valid = 1'b0;
    in_rx_byte  = 8'h00;
    tick(2);
    check("rst_regs", out_regs, 32'h0);
    check("rst_cnt", {24'h0, out_err_cnt}, 32'h0);
    check("rst_busy", {31'h0, out_busy}, 32'h0);
    in_reset = 1'b0;
    tick(1);

    // Good frame to register 3.
    send(8'h3F);
    check("t1_busy_hdr", {31'h0, out_busy}, 32'h1);
    send(8'h03);
    send(8'h33);
    check("t1_wr_vld", {31'h0, out_wr_valid}, 32'h1);
    check("t1_wr_addr", {24'h0, out_wr_addr}, 32'h03);
    check("t1_wr_data", {24'h0, out_wr_data}, 32'h33);
    check("t1_regs", out_regs, 32'h3300_0000);
    check("t1_busy_end", {31'h0, out_busy}, 32'h0);
    tick(1);
    check("t1_wr_pulse_end", {31'h0, out_wr_valid}, 32'h0);
    check("t1_no_err", n_err, 0);

    // Bad header then a good frame to register 0, back to back.
    send(8'h01);
    check("t2_err", {31'h0, out_err}, 32'h1);
    check("t2_cnt", {24'h0, out_err_cnt}, 32'h1);
    send(8'h3F);
    check("t2_err_end", {31'h0, out_err}, 32'h0);
    send(8'h00);
    send(8'hA5);
    check("t2_regs", out_regs, 32'h3300_00A5);

    // Out-of-range address: no write, error after data byte.
    send(8'h3F);
    send(8'h07);
    send(8'h55);
    check("t3_err", {31'h0, out_err}, 32'h1);
    check("t3_no_wr", {31'h0, out_wr_valid}, 32'h0);
    check("t3_cnt", {24'h0, out_err_cnt}, 32'h2);
    check("t3_regs", out_regs, 32'h3300_00A5);
    check("t3_addr_hold", {24'h0, out_wr_addr}, 32'h00);
    check("t3_data_hold", {24'h0, out_wr_data}, 32'hA5);

    // Reset mid-frame discards it silently.
    send(8'h3F);
    send(8'h01);
    check("t4_busy", {31'h0, out_busy}, 32'h1);
    err_base = n_err;
    in_reset = 1'b1;
    #1;
    check("t4_async_busy", {31'h0, out_busy}, 32'h0);
    check("t4_async_regs", out_regs, 32'h0);
    check("t4_async_cnt", {24'h0, out_err_cnt}, 32'h0);
    check("t4_async_wr", {out_wr_addr, out_wr_data}, 32'h0);
    tick(2);
    in_reset = 1'b0;
    tick(1);
    check("t4_err_none", n_err, err_base);
    send(8'h3F);
    send(8'h01);
    send(8'h77);
    check("t4_regs", out_regs, 32'h0000_7700);
    check("t4_cnt", {24'h0, out_err_cnt}, 32'h0);

    // Long inter-byte gaps inside a frame.
    send(8'h3F);
    tick(49);
    send(8'h02);
    check("t5_late_byte_busy", {31'h0, out_busy}, 32'h1);
    check("t5_late_byte_err", {31'h0, out_err}, 32'h0);
`ifdef UART_CMD_PARSER_FRAME_TIMEOUT_EN
    tick(49);
    check("t5_pre_expire_busy", {31'h0, out_busy}, 32'h1);
    check("t5_pre_expire_err", {31'h0, out_err}, 32'h0);
    tick(1);
    check("t5_expire_err", {31'h0, out_err}, 32'h1);
    check("t5_expire_busy", {31'h0, out_busy}, 32'h0);
    check("t5_expire_cnt", {24'h0, out_err_cnt}, 32'h1);
    tick(10);
    send(8'h44);
    check("t5_drop_err", {31'h0, out_err}, 32'h1);
    check("t5_drop_cnt", {24'h0, out_err_cnt}, 32'h2);
    check("t5_regs", out_regs, 32'h0000_7700);
    check("t5_n_wr", n_wr, 3);
`else
    tick(60);
    check("t5_wait_busy", {31'h0, out_busy}, 32'h1);
    check("t5_wait_cnt", {24'h0, out_err_cnt}, 32'h0);
    send(8'h44);
    check("t5_wr_vld", {31'h0, out_wr_valid}, 32'h1);
    check("t5_regs", out_regs, 32'h0044_7700);
    check("t5_n_wr", n_wr, 4);
`endif

    // Header value in the address slot is just an address (out of range here).
    send(8'h3F);
    send(8'h3F);
    check("t6_hdr_as_addr_busy", {31'h0, out_busy}, 32'h1);
    send(8'h12);
    check("t6_err", {31'h0, out_err}, 32'h1);
    check("t6_no_wr", {31'h0, out_wr_valid}, 32'h0);

    // Saturation of the error counter.
    do_reset();
    err_base = n_err;
    for (int i = 1; i <= 260; i++) begin
      send(8'h11);
      if (i == 254) check("t7_cnt_254", {24'h0, out_err_cnt}, 32'hFE);
      if (i == 255) check("t7_cnt_255", {24'h0, out_err_cnt}, 32'hFF);
    end
    check("t7_cnt_hold", {24'h0, out_err_cnt}, 32'hFF);
    check("t7_err_last", {31'h0, out_err}, 32'h1);
    check("t7_pulses", n_err - err_base, 260);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver inside main and consumes its byte stream.
- Assembles fixed 3-byte command frames: header, register address, data.
- Writes the data into a small configuration register file that drives mode/config for the rest of the datapath.
- Flags malformed frames with an error pulse and a saturating error counter.

Parameters:
- HEADER, 8'h3F, required first byte of every frame.
- NUM_REGS, 4, number of 8-bit config registers; valid addresses 0..NUM_REGS-1.
- CLKS_PER_BIT, 107, UART bit period in clocks; used only for the timeout default.
- TIMEOUT_CLKS, 20*CLKS_PER_BIT, maximum inter-byte gap inside a frame (FRAME_TIMEOUT_EN only).

Ports:
- in_clk  input  1  system clock
- in_reset  input  1  asynchronous, active-high reset
- in_rx_valid  input  1  one-cycle strobe from UART RX: in_rx_byte is valid
- in_rx_byte  input  8  received byte
- out_wr_valid  output  1  one-cycle pulse: a register was written
- out_wr_addr  output  8  address of the last write
- out_wr_data  output  8  data of the last write
- out_regs  output  NUM_REGS*8  flattened register file; reg k occupies bits [8k+7:8k]
- out_err  output  1  one-cycle pulse on any frame error
- out_err_cnt  output  8  saturating error count (stops at 255)
- out_busy  output  1  high while in ADDR or DATA

Behaviour:
- Clock and reset: one clock (in_clk). Reset is asynchronous and active-high (in_reset).
- Reset values: all outputs 0; out_regs all 0; FSM in IDLE; timeout counter 0. Reset mid-frame discards the partial frame with no error.
- FSM states:
  - IDLE: on in_rx_valid with byte==HEADER go to ADDR. Any other byte is dropped, pulses out_err, and increments out_err_cnt.
  - ADDR: on in_rx_valid, latch the byte as the address and go to DATA. A byte equal to HEADER here is taken as an address; there is no resync.
  - DATA: on in_rx_valid, return to IDLE and act on the latched address:
    - address < NUM_REGS: write the register.
    - otherwise: no write; pulse out_err and increment out_err_cnt.
- Write timing: data byte strobe at cycle N -> register updated at the N+1 clock edge. In the same cycle, out_wr_valid=1 and out_wr_addr/out_wr_data are updated. out_wr_addr/out_wr_data hold their values until the next write.
- A new header may arrive on the cycle immediately after the data byte; back-to-back frames have no dead cycle.
- in_rx_valid is one cycle wide. Consecutive-cycle strobes are each processed as separate bytes.
- out_err_cnt saturates at 8'hFF; further errors still pulse out_err.
- out_busy = (state != IDLE), combinational from the state register.

Optional Feature:
- Macro: UART_CMD_PARSER_FRAME_TIMEOUT_EN
- Defined:
  - A counter runs in ADDR and DATA and is cleared on every in_rx_valid and on entering IDLE.
  - When it reaches TIMEOUT_CLKS-1 with no in_rx_valid, the FSM returns to IDLE and pulses out_err / increments out_err_cnt.
  - A byte arriving in the expiry cycle wins: it is processed normally and no error is raised.
- Undefined: no counter is instantiated; a partial frame waits indefinitely.

Decomposition:
- Package uart_cmd_pkg holds:
  - FSM state encoding: IDLE=2'd0, ADDR=2'd1, DATA=2'd2.
  - Default header constant 8'h3F.
  - Error-cause localparams (BAD_HEADER, BAD_ADDR, TIMEOUT) for bench checking.
- One sub-module is natural: uart_cmd_timeout. It takes clear, run and expire signals, is parameterised by TIMEOUT_CLKS, and is instantiated only under the macro.

Test Plan:
- Bytes 3F,03,33 -> one out_wr_valid pulse, one cycle after the 0x33 strobe; out_wr_addr=03, out_wr_data=33; out_regs[31:24]=33; out_err never asserted.
- Bytes 01, then 3F,00,A5 -> out_err pulse on 01 and out_err_cnt=1; reg0=A5.
- Bytes 3F,07,55 with NUM_REGS=4 -> no write; out_err pulse after 55; out_err_cnt=1; out_regs unchanged.
- Bytes 3F,01 then reset asserted, then 3F,01,77 -> after reset all outputs are 0 and no error is raised; reg1=77.
- Macro defined, TIMEOUT_CLKS=50: bytes 3F,02 then 60-cycle gap then 44 -> timeout error at the 50th idle cycle; 44 is dropped as a bad header; out_err_cnt=2; reg2=0.
- 260 non-header bytes -> out_err_cnt=FF and holds; out_err pulses on each byte.
